// File: rtl/bist_pkg.sv
// Shared types and default sizing for the exhaustive XOR BIST controller.
package bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_COMPARE = 2'd2,
    ST_DONE    = 2'd3
  } bist_state_e;

  localparam int BIST_WIDTH  = 2;
  localparam int BIST_SETTLE = 2;
  localparam int BIST_CNT_W  = 8;

endpackage

// File: rtl/sat_counter.sv
// W-bit up counter that sticks at all-ones; clear has priority over increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] ONE = W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/xor_bist_ctrl.sv
// Walks every WIDTH-bit vector into two implementations of one function,
// compares their outputs after a settle interval and reports the result.
module xor_bist_ctrl
  import bist_pkg::*;
#(
  parameter int WIDTH         = BIST_WIDTH,
  parameter int SETTLE_CYCLES = BIST_SETTLE,
  parameter int CNT_W         = BIST_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] stim,
  input  logic             f_dut,
  input  logic             f_ref,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] fail_count,
  output logic             first_fail_valid,
  output logic [WIDTH-1:0] first_fail_vec,
  output bist_state_e      state_dbg
);

  // Run protocol: start is a one-cycle request, accepted only when busy=0
  // (IDLE or DONE); busy stays high until done rises, and done is held
  // until the next accepted start or reset.

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [SW-1:0]    SET_ONE     = SW'(1);
  localparam logic [WIDTH-1:0] STIM_ONE    = WIDTH'(1);

  bist_state_e   state_q, state_d;
  logic [SW-1:0] settle_cnt;
  logic          start_ok;
  logic          in_cmp;
  logic          last_vec;
  logic          mismatch;

  assign start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign in_cmp   = (state_q == ST_COMPARE);
  assign last_vec = (stim == '1);
  assign mismatch = in_cmp && (f_dut != f_ref);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start) state_d = ST_SETTLE;
      ST_SETTLE:  if (settle_cnt == SETTLE_LAST) state_d = ST_COMPARE;
      ST_COMPARE: state_d = last_vec ? ST_DONE : ST_SETTLE;
      ST_DONE:    if (start) state_d = ST_SETTLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q == ST_SETTLE) || (state_q == ST_COMPARE);
    done      = (state_q == ST_DONE);
    state_dbg = state_q;
  end

  // Settle counter runs only while staying in SETTLE, so each vector
  // starts from zero without a separate clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      settle_cnt <= '0;
    end else if ((state_q == ST_SETTLE) && (state_d == ST_SETTLE)) begin
      settle_cnt <= settle_cnt + SET_ONE;
    end else begin
      settle_cnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stim             <= '0;
      first_fail_valid <= 1'b0;
      first_fail_vec   <= '0;
      pass             <= 1'b0;
    end else if (start_ok) begin
      stim             <= '0;
      first_fail_valid <= 1'b0;
      first_fail_vec   <= '0;
      pass             <= 1'b0;
    end else if (in_cmp) begin
      if (!last_vec) begin
        stim <= stim + STIM_ONE;
      end else begin
        // The last vector's own mismatch is not yet in fail_count.
        pass <= (fail_count == '0) && !mismatch;
      end
      if (mismatch && !first_fail_valid) begin
        first_fail_valid <= 1'b1;
        first_fail_vec   <= stim;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_fail_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (start_ok),
    .inc   (mismatch),
    .count (fail_count)
  );

endmodule

// File: tb/tb_xor_bist_ctrl.sv
// Directed bench for xor_bist_ctrl: driver pushes expected run results,
// monitors pop and compare them whenever done rises.
module tb_xor_bist_ctrl;
  import bist_pkg::*;

  localparam int RUN_EDGES = 12;
  localparam int BOUND     = 60;

  typedef struct packed {
    logic [7:0]  fail_count;
    logic        ffv;
    logic [1:0]  ffvec;
    logic        pass;
    logic [23:0] stim_log;
  } exp_t;

  typedef struct packed {
    logic       fail_count;
    logic       ffv;
    logic [1:0] ffvec;
    logic       pass;
  } exp_s_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // main instance
  logic        start = 1'b0;
  logic [1:0]  stim;
  logic        f_dut, f_ref;
  logic        busy, done, pass;
  logic [7:0]  fail_count;
  logic        first_fail_valid;
  logic [1:0]  first_fail_vec;
  bist_state_e state_dbg;
  int          mode = 0;

  // saturation instance (CNT_W=1)
  logic        start_s = 1'b0;
  logic [1:0]  stim_s;
  logic        f_dut_s, f_ref_s;
  logic        busy_s, done_s, pass_s;
  logic [0:0]  fail_count_s;
  logic        ffv_s;
  logic [1:0]  ffvec_s;
  bist_state_e state_dbg_s;

  int n_tests = 0;
  int n_fail  = 0;

  exp_t   exp_q[$];
  exp_s_t exp_s_q[$];

  xor_bist_ctrl u_dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .stim             (stim),
    .f_dut            (f_dut),
    .f_ref            (f_ref),
    .busy             (busy),
    .done             (done),
    .pass             (pass),
    .fail_count       (fail_count),
    .first_fail_valid (first_fail_valid),
    .first_fail_vec   (first_fail_vec),
    .state_dbg        (state_dbg)
  );

  xor_bist_ctrl #(.CNT_W(1)) u_sat (
    .clk              (clk),
    .rst              (rst),
    .start            (start_s),
    .stim             (stim_s),
    .f_dut            (f_dut_s),
    .f_ref            (f_ref_s),
    .busy             (busy_s),
    .done             (done_s),
    .pass             (pass_s),
    .fail_count       (fail_count_s),
    .first_fail_valid (ffv_s),
    .first_fail_vec   (ffvec_s),
    .state_dbg        (state_dbg_s)
  );

  // gate models under test
  always_comb begin
    f_dut = stim[0] ^ stim[1];
    f_ref = stim[0] ^ stim[1];
    case (mode)
      1: f_ref = stim[0] | stim[1];
      2: f_dut = 1'b0;
      default: ;
    endcase
  end

  assign f_ref_s = stim_s[0] ^ stim_s[1];
  assign f_dut_s = ~f_ref_s;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int k;
    for (k = 0; k < BOUND; k++) begin
      @(negedge clk);
      if (done) break;
    end
    if (k == BOUND) check({name, "_timeout"}, 0, 1);
  endtask

  task automatic push_exp(input logic [7:0] fc, input logic ffv, input logic [1:0] vec, input logic p);
    exp_t e;
    e.fail_count = fc;
    e.ffv        = ffv;
    e.ffvec      = vec;
    e.pass       = p;
    e.stim_log   = 24'b000000_010101_101010_111111;
    exp_q.push_back(e);
  endtask

  // scoreboard monitor: main instance
  initial begin
    int   edge_cnt;
    bit   armed;
    logic prev_done;
    logic [23:0] slog;
    exp_t e;
    edge_cnt = 0; armed = 0; prev_done = 0; slog = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        armed = 0;
        prev_done = 0;
        continue;
      end
      if (armed) edge_cnt++;
      if (armed && busy) slog = {slog[21:0], stim};
      if (done && !prev_done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("fail_count", 32'(fail_count), 32'(e.fail_count));
          check("first_fail_valid", 32'(first_fail_valid), 32'(e.ffv));
          check("first_fail_vec", 32'(first_fail_vec), 32'(e.ffvec));
          check("pass", 32'(pass), 32'(e.pass));
          check("stim_sequence", 32'(slog), 32'(e.stim_log));
          check("done_latency", edge_cnt, RUN_EDGES);
          check("busy_with_done", 32'(busy), 0);
        end
        armed = 0;
      end
      if (start && !busy) begin
        armed = 1;
        edge_cnt = -1;
        slog = '0;
      end
      prev_done = done;
    end
  end

  // scoreboard monitor: saturation instance
  initial begin
    logic   prev_done_s;
    exp_s_t es;
    prev_done_s = 0;
    forever begin
      @(negedge clk);
      if (done_s && !prev_done_s) begin
        if (exp_s_q.size() == 0) begin
          check("sat_unexpected_done", 1, 0);
        end else begin
          es = exp_s_q.pop_front();
          check("sat_fail_count", 32'(fail_count_s), 32'(es.fail_count));
          check("sat_first_fail_valid", 32'(ffv_s), 32'(es.ffv));
          check("sat_first_fail_vec", 32'(ffvec_s), 32'(es.ffvec));
          check("sat_pass", 32'(pass_s), 32'(es.pass));
        end
      end
      prev_done_s = done_s;
    end
  end

  // stimulus
  initial begin
    int k;
    repeat (3) @(negedge clk);
    check("rst_stim", 32'(stim), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_pass", 32'(pass), 0);
    check("rst_fail_count", 32'(fail_count), 0);
    check("rst_ffv", 32'(first_fail_valid), 0);
    check("rst_ffvec", 32'(first_fail_vec), 0);
    check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    // matching XOR models
    mode = 0;
    push_exp(8'd0, 1'b0, 2'b00, 1'b1);
    pulse_start();
    wait_done("run_match");

    // REF = A|B, plus a start pulse at cycle 5 that must be ignored
    mode = 1;
    push_exp(8'd1, 1'b1, 2'b11, 1'b0);
    pulse_start();
    repeat (4) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done("run_or_ref");

    // DUT stuck at 0
    mode = 2;
    push_exp(8'd2, 1'b1, 2'b01, 1'b0);
    pulse_start();
    wait_done("run_stuck0");

    // restart straight out of DONE clears the previous result
    mode = 0;
    push_exp(8'd0, 1'b0, 2'b00, 1'b1);
    pulse_start();
    check("restart_done", 32'(done), 0);
    check("restart_fail_count", 32'(fail_count), 0);
    check("restart_ffv", 32'(first_fail_valid), 0);
    check("restart_stim", 32'(stim), 0);
    check("restart_busy", 32'(busy), 1);
    wait_done("run_restart");

    // reset during vector 10 aborts the run
    pulse_start();
    for (k = 0; k < BOUND; k++) begin
      @(negedge clk);
      if (stim == 2'b10) break;
    end
    if (k == BOUND) check("abort_wait_timeout", 0, 1);
    #2 rst = 1'b1;
    #1;
    check("abort_stim", 32'(stim), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    check("abort_pass", 32'(pass), 0);
    check("abort_fail_count", 32'(fail_count), 0);
    check("abort_ffv", 32'(first_fail_valid), 0);
    check("abort_ffvec", 32'(first_fail_vec), 0);
    check("abort_state", 32'(state_dbg), 32'(ST_IDLE));
    @(posedge clk);
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    push_exp(8'd0, 1'b0, 2'b00, 1'b1);
    pulse_start();
    wait_done("run_after_abort");

    // saturation with a 1-bit counter
    exp_s_q.push_back('{fail_count: 1'b1, ffv: 1'b1, ffvec: 2'b00, pass: 1'b0});
    @(posedge clk); #1 start_s = 1'b1;
    @(posedge clk); #1 start_s = 1'b0;
    for (k = 0; k < BOUND; k++) begin
      @(negedge clk);
      if (done_s) break;
    end
    if (k == BOUND) check("sat_timeout", 0, 1);

    repeat (3) @(negedge clk);
    check("sb_drain", exp_q.size(), 0);
    check("sat_sb_drain", exp_s_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
